// File: rtl/reg_dec16_if.sv
// Handshake and result bundle for reg_dec16. The master side feeds words and consumes results.
// The slave side is the decoder.
interface reg_dec16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] f_exp;
  logic        zero;
  logic        no_term;
  logic [15:0] rem_bits;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, f_exp, zero, no_term, rem_bits
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, f_exp, zero, no_term, rem_bits
  );
endinterface

// File: rtl/reg_dec16.sv
// Serial posit-16 regime decoder: STEP bits/cycle, ceil(min(run+1,15)/STEP) SCAN cycles, then DONE until out_ready.
// Single word in flight, in_ready only in IDLE; REG_DEC16_REM_EN builds the post-terminator remainder output.
module reg_dec16 #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_dec16_if.slave  bus
);

  generate
    if (!(STEP == 1 || STEP == 3 || STEP == 5 || STEP == 15)) begin : g_bad_step
      $error("reg_dec16: STEP must be 1, 3, 5 or 15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [14:0] sh;
  logic        p;
  logic [3:0]  run;
  logic [3:0]  used;

  logic        out_valid_q;
  logic [15:0] f_exp_q;
  logic        zero_q;
  logic        no_term_q;

  logic [3:0]  add;
  logic        found;
  logic [3:0]  run_nxt;
  logic [3:0]  used_nxt;
  logic        last;
  logic        zero_nxt;
  logic        no_term_nxt;
  logic [15:0] f_nxt;

  logic        unused_sign;
  assign unused_sign = bus.in_bits[15];

  // Count the bits equal to p in the current group, stopping at the terminator.
  always_comb begin
    add   = 4'd0;
    found = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (!found) begin
        if (sh[14-i] == p) begin
          add = add + 4'd1;
        end else begin
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    run_nxt     = run + add;
    used_nxt    = used + 4'(STEP);
    last        = found || (used_nxt == 4'd15);
    zero_nxt    = !p && (run_nxt == 4'd15);
    no_term_nxt = p && (run_nxt == 4'd15);
    f_nxt       = 16'd0;
    if (p) begin
      f_nxt = {12'd0, run_nxt} - 16'd1;
    end else if (!zero_nxt) begin
      f_nxt = 16'd0 - {12'd0, run_nxt};
    end
  end

`ifdef REG_DEC16_REM_EN
  logic [14:0] word;
  logic [15:0] rem_q;
  logic [15:0] rem_nxt;

  // A shift of 16 (run of 15) clears the remainder.
  always_comb begin
    rem_nxt = {word, 1'b0} << ({1'b0, run_nxt} + 5'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word  <= 15'd0;
      rem_q <= 16'd0;
    end else if (state == IDLE && bus.in_valid) begin
      word <= bus.in_bits[14:0];
    end else if (state == SCAN && last) begin
      rem_q <= rem_nxt;
    end
  end

  assign bus.rem_bits = rem_q;
`else
  assign bus.rem_bits = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh          <= 15'd0;
      p           <= 1'b0;
      run         <= 4'd0;
      used        <= 4'd0;
      out_valid_q <= 1'b0;
      f_exp_q     <= 16'd0;
      zero_q      <= 1'b0;
      no_term_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh    <= bus.in_bits[14:0];
            p     <= bus.in_bits[14];
            run   <= 4'd0;
            used  <= 4'd0;
            state <= SCAN;
          end
        end
        SCAN: begin
          sh   <= sh << STEP;
          run  <= run_nxt;
          used <= used_nxt;
          if (last) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            f_exp_q     <= f_nxt;
            zero_q      <= zero_nxt;
            no_term_q   <= no_term_nxt;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.f_exp     = f_exp_q;
  assign bus.zero      = zero_q;
  assign bus.no_term   = no_term_q;

endmodule

// File: tb/tb_reg_dec16.sv
// Bench for reg_dec16: four decoders (STEP 1, 3, 5, 15) share one stimulus stream.
// Results are checked against a bit-counting reference model.
module tb_reg_dec16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_bits;
  logic        out_ready;

  logic        ov [4];
  logic        ir [4];
  logic [15:0] fx [4];
  logic        zr [4];
  logic        nt [4];
  logic [15:0] rb [4];

  int steps [4] = '{1, 3, 5, 15};
  int ncmp = 0;
  int nerr = 0;
  int lat [4];
  bit timeout;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : 15;
    reg_dec16_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_bits   = in_bits;
    assign bus.out_ready = out_ready;
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign fx[g] = bus.f_exp;
    assign zr[g] = bus.zero;
    assign nt[g] = bus.no_term;
    assign rb[g] = bus.rem_bits;
    reg_dec16 #(.STEP(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got hang, need finish)");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [15:0] w, input int step,
                                output logic [15:0] f, output logic z, output logic n,
                                output logic [15:0] rem, output int lt);
    logic p;
    int run;
    bit stop;
    int k;
    int span;
    logic [31:0] t;
    p = w[14];
    run = 0;
    stop = 0;
    for (int i = 14; i >= 0; i--) begin
      if (!stop) begin
        if (w[i] == p) run++;
        else stop = 1;
      end
    end
    if (p) k = run - 1;
    else if (run == 15) k = 0;
    else k = -run;
    f = 16'(k);
    z = !p && run == 15;
    n = p && run == 15;
    t = {16'd0, w[14:0], 1'b0} << (run + 1);
`ifdef REG_DEC16_REM_EN
    rem = t[15:0];
`else
    rem = (t[15:0] & 16'h0000);
`endif
    span = (run + 1 > 15) ? 15 : run + 1;
    lt = (span + step - 1) / step + 1;
  endfunction

  function automatic logic [15:0] gen(input int e);
    int run;
    logic p;
    logic [15:0] w;
    run = (e >= 0) ? e + 1 : -e;
    p = (e >= 0);
    w = 16'($urandom);
    for (int i = 0; i < 15; i++) begin
      if (i < run) w[14-i] = p;
      else if (i == run) w[14-i] = !p;
    end
    return w;
  endfunction

  // Present one word, wait (bounded) until every decoder reports; caller sits #1 after an edge.
  task automatic send(input logic [15:0] w);
    bit all;
    in_valid = 1'b1;
    in_bits  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bits  = 16'($urandom);
    for (int g = 0; g < 4; g++) lat[g] = 0;
    timeout = 1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      all = 1;
      for (int g = 0; g < 4; g++) begin
        if (ov[g] && lat[g] == 0) lat[g] = cyc;
        if (lat[g] == 0) all = 0;
      end
      if (all) begin
        timeout = 0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_bits = 16'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      ncmp++;
      if ({ov[g], zr[g], nt[g], fx[g], rb[g]} !== 35'd0 || ir[g] !== 1'b1) begin
        nerr++;
        $display("FAIL reset[%0d]: got ov=%b ir=%b f=%h z=%b nt=%b rem=%h, need 0 1 0000 0 0 0000",
                 g, ov[g], ir[g], fx[g], zr[g], nt[g], rb[g]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] words [6] = '{16'h7000, 16'hF000, 16'h0800, 16'h4A00, 16'h7FFF, 16'h0000};
    logic [15:0] cf    [6] = '{16'h0002, 16'h0002, 16'hFFFD, 16'h0000, 16'h000E, 16'h0000};
    logic [1:0]  czn   [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    int          clat  [6] = '{5, 5, 5, 3, 16, 16};
    logic [15:0] ef, er;
    logic ez, en;
    int el;
    for (int t = 0; t < 6; t++) begin
      send(words[t]);
      ncmp++;
      if (timeout) begin
        nerr++;
        $display("FAIL directed_timeout %h: got no out_valid in 40 cycles, need out_valid", words[t]);
      end
      ncmp++;
      if (fx[0] !== cf[t] || {zr[0], nt[0]} !== czn[t] || lat[0] != clat[t]) begin
        nerr++;
        $display("FAIL directed_const %h: got f=%h zn=%b lat=%0d, need f=%h zn=%b lat=%0d",
                 words[t], fx[0], {zr[0], nt[0]}, lat[0], cf[t], czn[t], clat[t]);
      end
      for (int g = 0; g < 4; g++) begin
        model(words[t], steps[g], ef, ez, en, er, el);
        ncmp++;
        if (fx[g] !== ef || zr[g] !== ez || nt[g] !== en || rb[g] !== er || lat[g] != el) begin
          nerr++;
          $display("FAIL directed %h step%0d: got f=%h z=%b nt=%b rem=%h lat=%0d, need f=%h z=%b nt=%b rem=%h lat=%0d",
                   words[t], steps[g], fx[g], zr[g], nt[g], rb[g], lat[g], ef, ez, en, er, el);
        end
      end
      release_out();
    end
  endtask

  task automatic test_hold();
    logic [15:0] ef, er;
    logic ez, en;
    int el;
    send(16'h7000);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_bits = 16'($urandom);
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        model(16'h7000, steps[g], ef, ez, en, er, el);
        ncmp++;
        if (ov[g] !== 1'b1 || ir[g] !== 1'b0 || fx[g] !== ef || zr[g] !== ez || nt[g] !== en || rb[g] !== er) begin
          nerr++;
          $display("FAIL hold c%0d step%0d: got ov=%b ir=%b f=%h rem=%h, need ov=1 ir=0 f=%h rem=%h",
                   c, steps[g], ov[g], ir[g], fx[g], rb[g], ef, er);
        end
      end
    end
    in_valid = 1'b0;
    release_out();
    for (int c = 0; c < 3; c++) begin
      for (int g = 0; g < 4; g++) begin
        ncmp++;
        if (ov[g] !== 1'b0 || ir[g] !== 1'b1) begin
          nerr++;
          $display("FAIL hold_release c%0d step%0d: got ov=%b ir=%b, need ov=0 ir=1", c, steps[g], ov[g], ir[g]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    in_valid = 1'b1;
    in_bits  = 16'h7000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      ncmp++;
      if ({ov[g], zr[g], nt[g], fx[g], rb[g]} !== 35'd0 || ir[g] !== 1'b1) begin
        nerr++;
        $display("FAIL reset_mid step%0d: got ov=%b ir=%b f=%h z=%b nt=%b rem=%h, need all 0, ir=1",
                 steps[g], ov[g], ir[g], fx[g], zr[g], nt[g], rb[g]);
      end
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      for (int g = 0; g < 4; g++) if (ov[g] !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    ncmp++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL reset_mid_emit: got %0d out_valid samples, need 0", seen);
    end
  endtask

  task automatic test_random();
    logic [15:0] w, ef, er;
    logic ez, en;
    int el;
    for (int t = 0; t < 60; t++) begin
      w = 16'($urandom);
      if (t % 4 == 1) w = w | 16'h7FF0;
      if (t % 4 == 2) w = w & 16'h800F;
      out_ready = 1'b0;
      send(w);
      for (int g = 0; g < 4; g++) begin
        model(w, steps[g], ef, ez, en, er, el);
        ncmp++;
        if (timeout || fx[g] !== ef || zr[g] !== ez || nt[g] !== en || rb[g] !== er || lat[g] != el) begin
          nerr++;
          $display("FAIL random %h step%0d: got f=%h z=%b nt=%b rem=%h lat=%0d to=%b, need f=%h z=%b nt=%b rem=%h lat=%0d",
                   w, steps[g], fx[g], zr[g], nt[g], rb[g], lat[g], timeout, ef, ez, en, er, el);
        end
      end
      release_out();
    end
  endtask

  task automatic test_sweep();
    logic [15:0] w, ef, er;
    logic ez, en;
    int el;
    for (int e = -14; e <= 14; e++) begin
      w = gen(e);
      send(w);
      for (int g = 0; g < 4; g++) begin
        model(w, steps[g], ef, ez, en, er, el);
        ncmp++;
        if (timeout || fx[g] !== 16'(e) || lat[g] != el) begin
          nerr++;
          $display("FAIL sweep e=%0d step%0d: got f=%h lat=%0d, need f=%h lat=%0d",
                   e, steps[g], fx[g], lat[g], 16'(e), el);
        end
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/reg_dec16.md
Name: reg_dec16

Overview:
- Iterative regime decoder for 16-bit posits; the inverse of the regime generator (float exponent -> regime bitstring).
- Takes a 16-bit word whose bits [14:0] hold a regime field, left-aligned directly after the sign position.
- Scans the leading run serially and returns the signed exponent k.
- Also returns the bits after the regime terminator, left-aligned, for the exponent/fraction stages of the posit-to-float path.

Parameters:
- STEP, 1: regime bits examined per SCAN cycle. Legal values 1, 3, 5, 15, all of which divide 15. Any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept a word.
- in_bits  in  16  regime word. Bit 15 is ignored; the regime starts at bit 14.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- f_exp  out  16  signed regime value k, two's complement.
- zero  out  1  bits [14:0] were all zero (saturated/zero encoding).
- no_term  out  1  the run reached bit 0 without a terminator.
- rem_bits  out  16  post-terminator bits, left-aligned (see Optional Feature).

Behaviour:
- State machine: IDLE, SCAN, DONE.
- Reset (rst_n low at a clock edge), including mid-SCAN or in DONE:
  - state goes to IDLE; the in-flight word is discarded with no output.
  - out_valid=0, f_exp=0, zero=0, no_term=0, rem_bits=0.
- in_ready=1 only in IDLE. It is combinational from state.
- IDLE:
  - On in_valid & in_ready, capture in_bits[14:0] into a shift register and latch the run polarity p=in_bits[14].
  - Clear the run counter and go to SCAN.
- SCAN, each cycle:
  - Examine the next STEP bits MSB-first.
  - Count bits equal to p until the first bit != p (the terminator) or until bit 0 is consumed.
  - Go to DONE at the end of the cycle in which the terminator is found or all 15 bits are consumed.
  - Bits after the terminator inside the same STEP group are not counted.
- SCAN cycle count = ceil(min(run+1,15)/STEP).
- Latency: out_valid rises on the edge ending the last SCAN cycle.
  - STEP=1, run=3 (terminator at 4th bit): accept edge + 4 SCAN cycles; out_valid is high in the 5th cycle after the accept edge.
- Result encoding, run = length of the leading run (1..15):
  - p=1: f_exp = run-1 (range 0..14).
  - p=0, run<15: f_exp = -run (range -1..-14).
  - p=0, run=15: zero=1, f_exp=0.
  - no_term=1 iff run=15 and p=1.
  - rem_bits = {in_bits[14:0],1'b0} << (run+1), truncated to 16 bits. It is 0 whenever run=15.
- DONE:
  - out_valid=1; all outputs held stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - in_valid is ignored while not in IDLE.
  - No bypass: at most one word per (SCAN cycles + 2) clocks.
- Round-trip requirement: for every e in [-14,14], feeding the regime generator's output for e into reg_dec16 yields f_exp=e.

Optional Feature:
- Macro REG_DEC16_REM_EN.
- Defined: rem_bits is computed as above and registered on the DONE transition.
- Undefined: rem_bits is tied to 16'h0000 and the remainder shifter is not built; all other behaviour is identical.

Test Plan:
- STEP=1, in_bits=0x7000 -> f_exp=2, zero=0, no_term=0, rem_bits=0x0000; out_valid high exactly 5 cycles after the accept edge. Repeat with in_bits=0xF000 -> identical results (bit 15 ignored).
- in_bits=0x0800 -> f_exp=16'hFFFD (-3). in_bits=0x4A00 -> f_exp=0, rem_bits=0x5000 (macro defined) or 0x0000 (macro undefined).
- in_bits=0x7FFF -> f_exp=14, no_term=1, rem_bits=0. in_bits=0x0000 -> zero=1, f_exp=0; with STEP=1 there are 15 SCAN cycles.
- out_ready held low 3 cycles in DONE with in_valid=1 and in_bits changing -> outputs stable, in_ready=0, nothing captured; out_ready=1 -> IDLE next cycle, in_ready=1.
- rst_n low for one cycle during the 2nd SCAN cycle of 0x7000 -> next cycle IDLE, out_valid=0, all outputs 0; no result is ever emitted for that word.
- Sweep e=-14..14 through the regime generator, for each STEP in {1,3,5,15} -> f_exp=e every time. Latency matches ceil(min(run+1,15)/STEP)+1.
